// File: rtl/cfu_pkg.sv
// Shared types and function IDs for the popcount custom-function unit.
package cfu_pkg;

  typedef enum logic [1:0] {
    CFU_OK       = 2'b00,
    CFU_ERROR_OP = 2'b01
  } cfu_status_t;

  localparam int POPCNT_FUNC_COUNT = 0;
  localparam int POPCNT_FUNC_ACC   = 1;

endpackage

// File: rtl/compressors.sv
// Combinational population count of a W-bit operand; result is CW bits wide.
module compressors #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at ptr; ptr moves past
// the winner only when a grant is issued.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_hit;
  int            w_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant      = '0;
    w_hit      = 1'b0;
    w_next_ptr = r_ptr;
    w_idx      = 0;
    // Grants are suppressed during reset so req_ready stays low until release.
    if (en && !rst) begin
      for (int k = 0; k < N; k++) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= N) w_idx = w_idx - N;
        if (!w_hit && req[w_idx]) begin
          w_hit        = 1'b1;
          grant[w_idx] = 1'b1;
          w_next_ptr   = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/popcount_arb_cfu.sv
// N_REQ requesters share one popcount datapath behind a round-robin arbiter;
// a single output register holds the response for its owner lane.
module popcount_arb_cfu
  import cfu_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int FUNC_ID_W = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][FUNC_ID_W-1:0] req_func,
  input  logic [N_REQ-1:0][DATA_W-1:0]    req_data0,
  input  logic [N_REQ-1:0][DATA_W-1:0]    req_data1,
  output logic [N_REQ-1:0]                resp_valid,
  input  logic [N_REQ-1:0]                resp_ready,
  output cfu_status_t                     resp_status,
  output logic [DATA_W-1:0]               resp_data
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(DATA_W + 1);

  logic                 r_out_valid;
  logic [OW-1:0]        r_owner;
  logic [DATA_W-1:0]    r_data;
  cfu_status_t          r_status;

  logic                 w_grant_en;
  logic [N_REQ-1:0]     w_grant;
  logic                 w_any_grant;
  logic [OW-1:0]        w_grant_idx;
  logic [FUNC_ID_W-1:0] w_func;
  logic [DATA_W-1:0]    w_data0;
  logic [DATA_W-1:0]    w_data1;
  logic [CW-1:0]        w_popcnt;
  logic [DATA_W-1:0]    w_result;
  cfu_status_t          w_status;

  // A new grant is allowed when the output register is empty or draining now.
  assign w_grant_en  = !r_out_valid || resp_ready[r_owner];
  assign w_any_grant = |w_grant;
  assign req_ready   = w_grant;

  rr_arb #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (w_grant_en),
    .grant (w_grant)
  );

  always_comb begin
    w_func      = '0;
    w_data0     = '0;
    w_data1     = '0;
    w_grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_func      = w_func  | req_func[i];
        w_data0     = w_data0 | req_data0[i];
        w_data1     = w_data1 | req_data1[i];
        w_grant_idx = OW'(i);
      end
    end
  end

  compressors #(.W(DATA_W), .CW(CW)) u_popcnt (
    .i_data  (w_data0),
    .o_count (w_popcnt)
  );

  always_comb begin
    w_result = '0;
    w_status = CFU_ERROR_OP;
    if (w_func == FUNC_ID_W'(POPCNT_FUNC_COUNT)) begin
      w_result = DATA_W'(w_popcnt);
      w_status = CFU_OK;
    end else if (w_func == FUNC_ID_W'(POPCNT_FUNC_ACC)) begin
      w_result = DATA_W'(w_popcnt) + w_data1;
      w_status = CFU_OK;
    end
  end

  // Data and status load only on a grant, so they hold while backpressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_owner     <= '0;
      r_data      <= '0;
      r_status    <= CFU_OK;
    end else if (w_any_grant) begin
      r_out_valid <= 1'b1;
      r_owner     <= w_grant_idx;
      r_data      <= w_result;
      r_status    <= w_status;
    end else if (r_out_valid && resp_ready[r_owner]) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (r_out_valid) resp_valid[r_owner] = 1'b1;
  end

  assign resp_data   = r_data;
  assign resp_status = r_status;

endmodule
